inverse_scaling: RTL and testbench

Converts four screen-space vertices (X/Y already scaled by 320/240 in Q10 fixed point) back to normalized raw coordinates. It is the inverse of the forward viewport scaling stage and is used by the pick/readback path. A packet is accepted through a valid/ready handshake. One shared radix-2 restoring divider computes the eight X/Y quotients sequentially. The result packet is presented until the consumer accepts it.

---
 rtl/inverse_scaling.sv | 247 ++++++++++++++++++++++++
 tb/tb_inverse_scaling.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_scaling.sv
// inverse_scaling: maps four screen-space vertices back to normalized raw coordinates,
// walking the eight X/Y quotients through one shared restoring divider.
module inverse_scaling #(
  parameter int           W          = 21,
  parameter logic [W-1:0] DIV_X      = 21'h2800,
  parameter logic [W-1:0] DIV_Y      = 21'h1e00,
  parameter int           FRAC_SHIFT = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] vtx1_X_scaled,
  input  logic [W-1:0] vtx1_Y_scaled,
  input  logic [W-1:0] vtx1_Z_scaled,
  input  logic [W-1:0] vtx2_X_scaled,
  input  logic [W-1:0] vtx2_Y_scaled,
  input  logic [W-1:0] vtx2_Z_scaled,
  input  logic [W-1:0] vtx3_X_scaled,
  input  logic [W-1:0] vtx3_Y_scaled,
  input  logic [W-1:0] vtx3_Z_scaled,
  input  logic [W-1:0] vtx4_X_scaled,
  input  logic [W-1:0] vtx4_Y_scaled,
  input  logic [W-1:0] vtx4_Z_scaled,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] vtx1_X_raw,
  output logic [W-1:0] vtx1_Y_raw,
  output logic [W-1:0] vtx1_Z_raw,
  output logic [W-1:0] vtx2_X_raw,
  output logic [W-1:0] vtx2_Y_raw,
  output logic [W-1:0] vtx2_Z_raw,
  output logic [W-1:0] vtx3_X_raw,
  output logic [W-1:0] vtx3_Y_raw,
  output logic [W-1:0] vtx3_Z_raw,
  output logic [W-1:0] vtx4_X_raw,
  output logic [W-1:0] vtx4_Y_raw,
  output logic [W-1:0] vtx4_Z_raw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [30:0] dvd_q;
  logic [W:0]  rem_q;
  logic        sign_q;
  logic [W-1:0] xy_lat_q [8];
  logic [W-1:0] xy_raw_q [8];
  logic [W-1:0] z_raw_q  [4];

  logic [W-1:0] xy_in_s [8];
  logic [W-1:0] z_in_s  [4];
  logic [W-1:0] divisor_s;
  logic [W:0]   rem_sh_s;
  logic [W:0]   rem_nx_s;
  logic         qbit_s;
  logic [W-1:0] quot_signed_s;
  logic [W-1:0] op_src_s;
  logic [31:0]  prep_s;

  // Returns {sign, |N|} where N is the sign-extended value shifted up by FRAC_SHIFT.
  function automatic logic [31:0] prep_operand(input logic [W-1:0] v);
    logic [31:0] n;
    logic [31:0] mag;
    n = 32'($signed(v)) << FRAC_SHIFT;
    if (n[31]) begin
      mag = ~n + 32'd1;
    end else begin
      mag = n;
    end
    return {n[31], mag[30:0]};
  endfunction

  assign xy_in_s[0] = vtx1_X_scaled;
  assign xy_in_s[1] = vtx1_Y_scaled;
  assign xy_in_s[2] = vtx2_X_scaled;
  assign xy_in_s[3] = vtx2_Y_scaled;
  assign xy_in_s[4] = vtx3_X_scaled;
  assign xy_in_s[5] = vtx3_Y_scaled;
  assign xy_in_s[6] = vtx4_X_scaled;
  assign xy_in_s[7] = vtx4_Y_scaled;
  assign z_in_s[0]  = vtx1_Z_scaled;
  assign z_in_s[1]  = vtx2_Z_scaled;
  assign z_in_s[2]  = vtx3_Z_scaled;
  assign z_in_s[3]  = vtx4_Z_scaled;

  // Restoring divide step, signed quotient and next-operand preparation.
  always_comb begin
    divisor_s = idx_q[0] ? DIV_Y : DIV_X;
    rem_sh_s  = {rem_q[W-1:0], dvd_q[30]};
    if (rem_sh_s >= {1'b0, divisor_s}) begin
      rem_nx_s = rem_sh_s - {1'b0, divisor_s};
      qbit_s   = 1'b1;
    end else begin
      rem_nx_s = rem_sh_s;
      qbit_s   = 1'b0;
    end
    if (sign_q) begin
      quot_signed_s = {W{1'b0}} - dvd_q[W-1:0];
    end else begin
      quot_signed_s = dvd_q[W-1:0];
    end
    if (state_q == IDLE) begin
      op_src_s = xy_in_s[0];
    end else begin
      op_src_s = xy_lat_q[idx_q + 3'd1];
    end
    prep_s = prep_operand(op_src_s);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        if (cnt_q == 5'd30) begin
          state_d = STORE;
        end else begin
          state_d = DIV;
        end
      end
      STORE: begin
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand latch, divider iterations and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 5'd0;
      idx_q  <= 3'd0;
      dvd_q  <= 31'd0;
      rem_q  <= {(W+1){1'b0}};
      sign_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        xy_lat_q[i] <= {W{1'b0}};
        xy_raw_q[i] <= {W{1'b0}};
      end
      for (int i = 0; i < 4; i++) begin
        z_raw_q[i] <= {W{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 8; i++) begin
              xy_lat_q[i] <= xy_in_s[i];
            end
            for (int i = 0; i < 4; i++) begin
              z_raw_q[i] <= z_in_s[i];
            end
            idx_q  <= 3'd0;
            cnt_q  <= 5'd0;
            rem_q  <= {(W+1){1'b0}};
            dvd_q  <= prep_s[30:0];
            sign_q <= prep_s[31];
          end
        end
        DIV: begin
          dvd_q <= {dvd_q[29:0], qbit_s};
          rem_q <= rem_nx_s;
          cnt_q <= cnt_q + 5'd1;
        end
        STORE: begin
          xy_raw_q[idx_q] <= quot_signed_s;
          idx_q           <= idx_q + 3'd1;
          if (idx_q != 3'd7) begin
            cnt_q  <= 5'd0;
            rem_q  <= {(W+1){1'b0}};
            dvd_q  <= prep_s[30:0];
            sign_q <= prep_s[31];
          end
        end
        DONE: begin
          cnt_q <= cnt_q;
        end
        default: begin
          cnt_q <= 5'd0;
        end
      endcase
    end
  end

  assign vtx1_X_raw = xy_raw_q[0];
  assign vtx1_Y_raw = xy_raw_q[1];
  assign vtx2_X_raw = xy_raw_q[2];
  assign vtx2_Y_raw = xy_raw_q[3];
  assign vtx3_X_raw = xy_raw_q[4];
  assign vtx3_Y_raw = xy_raw_q[5];
  assign vtx4_X_raw = xy_raw_q[6];
  assign vtx4_Y_raw = xy_raw_q[7];
  assign vtx1_Z_raw = z_raw_q[0];
  assign vtx2_Z_raw = z_raw_q[1];
  assign vtx3_Z_raw = z_raw_q[2];
  assign vtx4_Z_raw = z_raw_q[3];

endmodule

// File: tb/tb_inverse_scaling.sv
// Directed and round-trip bench for inverse_scaling with hand-computed expectations.
module tb_inverse_scaling;
  localparam int W = 21;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic signed [W-1:0] in_x [4];
  logic signed [W-1:0] in_y [4];
  logic signed [W-1:0] in_z [4];
  logic signed [W-1:0] raw_x [4];
  logic signed [W-1:0] raw_y [4];
  logic signed [W-1:0] raw_z [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inverse_scaling dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .vtx1_X_scaled(in_x[0]), .vtx1_Y_scaled(in_y[0]), .vtx1_Z_scaled(in_z[0]),
    .vtx2_X_scaled(in_x[1]), .vtx2_Y_scaled(in_y[1]), .vtx2_Z_scaled(in_z[1]),
    .vtx3_X_scaled(in_x[2]), .vtx3_Y_scaled(in_y[2]), .vtx3_Z_scaled(in_z[2]),
    .vtx4_X_scaled(in_x[3]), .vtx4_Y_scaled(in_y[3]), .vtx4_Z_scaled(in_z[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .vtx1_X_raw(raw_x[0]), .vtx1_Y_raw(raw_y[0]), .vtx1_Z_raw(raw_z[0]),
    .vtx2_X_raw(raw_x[1]), .vtx2_Y_raw(raw_y[1]), .vtx2_Z_raw(raw_z[1]),
    .vtx3_X_raw(raw_x[2]), .vtx3_Y_raw(raw_y[2]), .vtx3_Z_raw(raw_z[2]),
    .vtx4_X_raw(raw_x[3]), .vtx4_Y_raw(raw_y[3]), .vtx4_Z_raw(raw_z[3])
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_inputs(input int x0, y0, x1, y1, x2, y2, x3, y3, z0, z1, z2, z3);
    in_x[0] = W'(x0); in_y[0] = W'(y0); in_z[0] = W'(z0);
    in_x[1] = W'(x1); in_y[1] = W'(y1); in_z[1] = W'(z1);
    in_x[2] = W'(x2); in_y[2] = W'(y2); in_z[2] = W'(z2);
    in_x[3] = W'(x3); in_y[3] = W'(y3); in_z[3] = W'(z3);
  endtask

  task automatic start_packet();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid rises (bounded).
  task automatic wait_out(output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) busy_bad++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_inputs(11, 22, 33, 44, 55, 66, 77, 88, 1, 2, 3, 4);
    #23;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== 21'sd0 || raw_y[i] !== 21'sd0 || raw_z[i] !== 21'sd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: x=%0d y=%0d z=%0d expected 0", i, raw_x[i], raw_y[i], raw_z[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_out_ready: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat, bb;
    int ex[4] = '{1, -1, 2, 0};
    int ey[4] = '{2, -2, 4, 0};
    set_inputs(10, 15, -10, -15, 20, 30, 0, 0, 7, 7, 7, 7);
    start_packet();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: in_ready=%b expected 0", in_ready);
    end
    set_inputs(555, 555, 555, 555, 555, 555, 555, 555, 9, 9, 9, 9);
    wait_out(lat, bb);
    n_checks++;
    if (lat !== 256) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 256", lat);
    end
    n_checks++;
    if (bb !== 0) begin
      n_fail++;
      $display("FAIL basic_busy_in_ready: got %0d high cycles expected 0", bb);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== W'(ex[i]) || raw_y[i] !== W'(ey[i]) || raw_z[i] !== 21'sd7) begin
        n_fail++;
        $display("FAIL basic_vtx[%0d]: got %0d,%0d,%0d expected %0d,%0d,7", i, raw_x[i], raw_y[i], raw_z[i], ex[i], ey[i]);
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_ready: got %b expected 0", in_ready);
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_truncation_extremes();
    int lat, bb;
    int ex[4] = '{0, 0, 104857, -104857};
    int ey[4] = '{-1, 1, -139810, 139810};
    int ez[4] = '{-5, 1048575, -1048576, 123};
    set_inputs(3, -8, -3, 11, 1048575, -1048576, -1048576, 1048575, -5, 1048575, -1048576, 123);
    start_packet();
    wait_out(lat, bb);
    n_checks++;
    if (lat !== 256) begin
      n_fail++;
      $display("FAIL trunc_latency: got %0d expected 256", lat);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== W'(ex[i]) || raw_y[i] !== W'(ey[i]) || raw_z[i] !== W'(ez[i])) begin
        n_fail++;
        $display("FAIL trunc_vtx[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, raw_x[i], raw_y[i], raw_z[i], ex[i], ey[i], ez[i]);
      end
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, bb, hold_bad;
    int ex[4]  = '{4, -5, 10, 0};
    int ey[4]  = '{6, -8, 10, -2};
    int ez[4]  = '{1, 2, 3, 4};
    int ex2[4] = '{-10, 100, 3, -1024};
    int ey2[4] = '{-10, 100, 1, 1024};
    int ez2[4] = '{9, 8, 7, 6};
    set_inputs(40, 45, -50, -60, 100, 75, -7, -22, 1, 2, 3, 4);
    start_packet();
    set_inputs(-100, -75, 1000, 750, 33, 8, -10240, 7680, 9, 8, 7, 6);
    in_valid = 1'b1;
    wait_out(lat, bb);
    n_checks++;
    if (lat !== 256 || bb !== 0) begin
      n_fail++;
      $display("FAIL bp_first: latency %0d busy_in_ready %0d expected 256/0", lat, bb);
    end
    hold_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
      for (int i = 0; i < 4; i++) begin
        if (raw_x[i] !== W'(ex[i]) || raw_y[i] !== W'(ey[i]) || raw_z[i] !== W'(ez[i])) hold_bad++;
      end
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable samples expected 0", hold_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== W'(ex[i]) || raw_y[i] !== W'(ey[i]) || raw_z[i] !== W'(ez[i])) begin
        n_fail++;
        $display("FAIL bp_vtx[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, raw_x[i], raw_y[i], raw_z[i], ex[i], ey[i], ez[i]);
      end
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: in_ready=%b expected 0", in_ready);
    end
    wait_out(lat, bb);
    n_checks++;
    if (lat !== 256) begin
      n_fail++;
      $display("FAIL bp_second_latency: got %0d expected 256", lat);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== W'(ex2[i]) || raw_y[i] !== W'(ey2[i]) || raw_z[i] !== W'(ez2[i])) begin
        n_fail++;
        $display("FAIL bp2_vtx[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, raw_x[i], raw_y[i], raw_z[i], ex2[i], ey2[i], ez2[i]);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, bb;
    set_inputs(20, 0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
    start_packet();
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raw_x[i] !== 21'sd0 || raw_y[i] !== 21'sd0 || raw_z[i] !== 21'sd0) begin
        n_fail++;
        $display("FAIL midreset_outputs[%0d]: x=%0d y=%0d z=%0d expected 0", i, raw_x[i], raw_y[i], raw_z[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_accept: in_ready=%b expected 0", in_ready);
    end
    wait_out(lat, bb);
    n_checks++;
    if (lat !== 256 || raw_x[0] !== 21'sd2 || raw_z[0] !== 21'sd5) begin
      n_fail++;
      $display("FAIL midreset_result: latency %0d x=%0d z=%0d expected 256/2/5", lat, raw_x[0], raw_z[0]);
    end
    consume();
  endtask

  task automatic test_round_trip();
    int lat, bb;
    int rx[4];
    int ry[4];
    for (int p = 0; p < 250; p++) begin
      for (int i = 0; i < 4; i++) begin
        rx[i] = int'($urandom_range(200000)) - 100000;
        ry[i] = int'($urandom_range(200000)) - 100000;
        in_x[i] = W'((rx[i] * 10240) >>> 10);
        in_y[i] = W'((ry[i] * 7680) >>> 10);
        in_z[i] = W'(p);
      end
      start_packet();
      wait_out(lat, bb);
      n_checks++;
      if (lat !== 256) begin
        n_fail++;
        $display("FAIL rt_latency[%0d]: got %0d expected 256", p, lat);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (raw_x[i] !== W'(rx[i])) begin
          n_fail++;
          $display("FAIL rt_x[%0d.%0d]: got %0d expected %0d", p, i, raw_x[i], rx[i]);
        end
        n_checks++;
        if (!(raw_y[i] === W'(ry[i]) || (ry[i] > 0 && raw_y[i] === W'(ry[i] - 1)))) begin
          n_fail++;
          $display("FAIL rt_y[%0d.%0d]: got %0d expected %0d or one toward zero", p, i, raw_y[i], ry[i]);
        end
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation_extremes();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
